// File: rtl/sn74hc595_multi_seg8_driver.sv
// Serial driver for a chain of SN74HC595 shift registers feeding a
// multi-digit 8-segment display. A request captures the encoded digits,
// shifts them out MSB first (top digit first) and then pulses the latch.
module sn74hc595_multi_seg8_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned STEP_LENGTH    = 250,
  parameter int unsigned COMMON_ANODE   = 1,
  parameter int unsigned BLANK_LEADING  = 0,
  parameter int unsigned REFRESH_PERIOD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [4*DIGITS-1:0]   nums,
  input  logic [DIGITS-1:0]     dp,
  output logic                  busy,
  output logic                  done,
  output logic                  clk_serial,
  output logic                  data,
  output logic                  load
);

  localparam int unsigned B      = 8 * DIGITS;
  localparam int unsigned STEP_W = $clog2(2 * STEP_LENGTH);
  localparam int unsigned BIT_W  = $clog2(B);

  localparam logic [STEP_W-1:0] HALF_END = STEP_W'(STEP_LENGTH - 1);
  localparam logic [STEP_W-1:0] FULL_END = STEP_W'(2 * STEP_LENGTH - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(B - 1);
  localparam logic [B-1:0]      ALL_OFF  = (COMMON_ANODE != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               t0;
  logic               t1;
  logic               start_req;
  logic               pending;
  logic               refresh_hit;
  logic               go;
  logic               latch_enter;
  logic               finish;
  logic [STEP_W-1:0]  step_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   next_idx;
  logic [B-1:0]       buffer;
  logic [B-1:0]       enc_word;
  logic [3:0]         digit;
  logic               pt;
  logic [7:0]         byte_v;
  logic               leading;

  // Common-anode segment codes: bit 7 = dp, bits 6..0 = g..a, active-low.
  function automatic logic [7:0] glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'h0:    g = 8'hC0;
      4'h1:    g = 8'hF9;
      4'h2:    g = 8'hA4;
      4'h3:    g = 8'hB0;
      4'h4:    g = 8'h99;
      4'h5:    g = 8'h92;
      4'h6:    g = 8'h82;
      4'h7:    g = 8'hF8;
      4'h8:    g = 8'h80;
      4'h9:    g = 8'h90;
      4'hA:    g = 8'h88;
      4'hB:    g = 8'h83;
      4'hC:    g = 8'hC6;
      4'hD:    g = 8'hA1;
      4'hE:    g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // Two-flop trigger synchroniser; a request is its rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t0 <= 1'b0;
      t1 <= 1'b0;
    end else begin
      t0 <= trigger;
      t1 <= t0;
    end
  end

  assign start_req = t0 & ~t1;

  // Encode all digits, scanning from the top digit so leading-zero
  // blanking can stop at the first significant digit.
  always_comb begin
    enc_word = '0;
    digit    = '0;
    pt       = 1'b0;
    byte_v   = '0;
    leading  = (BLANK_LEADING != 0);
    for (int unsigned k = 0; k < DIGITS; k++) begin
      digit = nums[4*(DIGITS-1-k) +: 4];
      pt    = dp[DIGITS-1-k];
      if (leading && (k != DIGITS - 1) && (digit == 4'h0) && !pt) begin
        byte_v = 8'hFF;
      end else begin
        leading = 1'b0;
        byte_v  = glyph(digit);
        if (pt) byte_v[7] = 1'b0;
      end
      if (COMMON_ANODE == 0) byte_v = ~byte_v;
      enc_word[8*(DIGITS-1-k) +: 8] = byte_v;
    end
  end

  // Periodic refresh: counts idle time after each done, never wraps.
  generate
    if (REFRESH_PERIOD > 0) begin : g_refresh
      localparam int unsigned RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
      localparam logic [RW-1:0] REFRESH_END = RW'(REFRESH_PERIOD - 1);
      logic [RW-1:0] refresh_cnt;

      // Cleared together with the rising edge of done so the next start
      // lands REFRESH_PERIOD cycles after the done cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          refresh_cnt <= '0;
        end else if (finish) begin
          refresh_cnt <= '0;
        end else if (refresh_cnt != REFRESH_END) begin
          refresh_cnt <= refresh_cnt + 1'b1;
        end
      end

      assign refresh_hit = (state_q == IDLE) && (refresh_cnt == REFRESH_END);
    end else begin : g_no_refresh
      assign refresh_hit = 1'b0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control strobes.
  always_comb begin
    state_d     = state_q;
    go          = 1'b0;
    latch_enter = 1'b0;
    finish      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req || pending || refresh_hit) begin
          go      = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if ((step_cnt == FULL_END) && (bit_cnt == LAST_BIT)) begin
          latch_enter = 1'b1;
          state_d     = LATCH;
        end
      end
      LATCH: begin
        if (step_cnt == HALF_END) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One queued request: any number of edges during a transfer collapse here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (go) begin
      pending <= 1'b0;
    end else if (start_req && (state_q != IDLE)) begin
      pending <= 1'b1;
    end
  end

  assign next_idx = LAST_BIT - bit_cnt - BIT_W'(1);

  // Serial datapath: data changes at the start of each 2S bit slot,
  // clk_serial rises mid-slot, load is held for S cycles after the last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer     <= ALL_OFF;
      step_cnt   <= '0;
      bit_cnt    <= '0;
      clk_serial <= 1'b0;
      data       <= 1'b0;
      load       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= finish;
      if (go) begin
        buffer     <= enc_word;
        data       <= enc_word[B-1];
        busy       <= 1'b1;
        step_cnt   <= '0;
        bit_cnt    <= '0;
        clk_serial <= 1'b0;
      end else if (state_q == SHIFT) begin
        if (step_cnt == FULL_END) begin
          step_cnt   <= '0;
          clk_serial <= 1'b0;
          if (latch_enter) begin
            load <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            data    <= buffer[next_idx];
          end
        end else begin
          step_cnt <= step_cnt + 1'b1;
          if (step_cnt == HALF_END) clk_serial <= 1'b1;
        end
      end else if (state_q == LATCH) begin
        if (finish) begin
          load     <= 1'b0;
          busy     <= 1'b0;
          step_cnt <= '0;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sn74hc595_multi_seg8_driver.sv
module tb_sn74hc595_multi_seg8_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        ca_trigger = 1'b0, cc_trigger = 1'b0, bl_trigger = 1'b0, rf_trigger = 1'b0;
  logic [15:0] ca_nums = '0, cc_nums = '0, bl_nums = '0, rf_nums = 16'h1111;
  logic [3:0]  ca_dp = '0, cc_dp = '0, bl_dp = '0, rf_dp = '0;
  logic ca_busy, ca_done, ca_sclk, ca_data, ca_load;
  logic cc_busy, cc_done, cc_sclk, cc_data, cc_load;
  logic bl_busy, bl_done, bl_sclk, bl_data, bl_load;
  logic rf_busy, rf_done, rf_sclk, rf_data, rf_load;

  int   sel = 0;
  logic mon_busy, mon_done, mon_sclk, mon_data, mon_load;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sn74hc595_multi_seg8_driver #(.DIGITS(4), .STEP_LENGTH(2), .COMMON_ANODE(1),
    .BLANK_LEADING(0), .REFRESH_PERIOD(0)) u_ca (
    .clk(clk), .rst(rst), .trigger(ca_trigger), .nums(ca_nums), .dp(ca_dp),
    .busy(ca_busy), .done(ca_done), .clk_serial(ca_sclk), .data(ca_data), .load(ca_load));

  sn74hc595_multi_seg8_driver #(.DIGITS(4), .STEP_LENGTH(2), .COMMON_ANODE(0),
    .BLANK_LEADING(0), .REFRESH_PERIOD(0)) u_cc (
    .clk(clk), .rst(rst), .trigger(cc_trigger), .nums(cc_nums), .dp(cc_dp),
    .busy(cc_busy), .done(cc_done), .clk_serial(cc_sclk), .data(cc_data), .load(cc_load));

  sn74hc595_multi_seg8_driver #(.DIGITS(4), .STEP_LENGTH(2), .COMMON_ANODE(1),
    .BLANK_LEADING(1), .REFRESH_PERIOD(0)) u_bl (
    .clk(clk), .rst(rst), .trigger(bl_trigger), .nums(bl_nums), .dp(bl_dp),
    .busy(bl_busy), .done(bl_done), .clk_serial(bl_sclk), .data(bl_data), .load(bl_load));

  sn74hc595_multi_seg8_driver #(.DIGITS(4), .STEP_LENGTH(2), .COMMON_ANODE(1),
    .BLANK_LEADING(0), .REFRESH_PERIOD(20)) u_rf (
    .clk(clk), .rst(rst), .trigger(rf_trigger), .nums(rf_nums), .dp(rf_dp),
    .busy(rf_busy), .done(rf_done), .clk_serial(rf_sclk), .data(rf_data), .load(rf_load));

  // Route the selected instance to the shared capture logic.
  always_comb begin
    mon_busy = ca_busy; mon_done = ca_done; mon_sclk = ca_sclk;
    mon_data = ca_data; mon_load = ca_load;
    case (sel)
      1: begin mon_busy = cc_busy; mon_done = cc_done; mon_sclk = cc_sclk; mon_data = cc_data; mon_load = cc_load; end
      2: begin mon_busy = bl_busy; mon_done = bl_done; mon_sclk = bl_sclk; mon_data = bl_data; mon_load = bl_load; end
      3: begin mon_busy = rf_busy; mon_done = rf_done; mon_sclk = rf_sclk; mon_data = rf_data; mon_load = rf_load; end
      default: ;
    endcase
  end

  // Waits for the next transfer on the selected instance and decodes it:
  // one bit per clk_serial rising edge, sampled on the falling clk edge.
  task automatic capture(output logic [31:0] word, output int nbits, output int blen,
                         output int llen, output logic done_end, output int t0c,
                         output logic timeout);
    int   w;
    logic prev;
    word = '0; nbits = 0; blen = 0; llen = 0; done_end = 1'b0; t0c = 0;
    timeout = 1'b0; prev = 1'b0; w = 0;
    @(negedge clk);
    while (!mon_busy && w < 400) begin
      w++;
      @(negedge clk);
    end
    if (!mon_busy) begin
      timeout = 1'b1;
      return;
    end
    t0c = cyc;
    while (mon_busy && blen < 1000) begin
      blen++;
      if (mon_load) llen++;
      if (mon_sclk && !prev) begin
        word = {word[30:0], mon_data};
        nbits++;
      end
      prev = mon_sclk;
      @(negedge clk);
    end
    done_end = mon_done;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ca_busy, ca_done, ca_sclk, ca_data, ca_load} !== 5'b0) begin
      errors++;
      $display("FAIL reset_hold outputs=%b required=00000", {ca_busy, ca_done, ca_sclk, ca_data, ca_load});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({ca_busy, ca_done, ca_sclk, ca_data, ca_load} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle outputs=%b required=00000", {ca_busy, ca_done, ca_sclk, ca_data, ca_load});
    end
  endtask

  task automatic test_basic();
    logic [31:0] word; int nbits, blen, llen, t0c, dcyc; logic dend, tmo;
    sel = 0; ca_nums = 16'h1234; ca_dp = 4'b0100;
    @(negedge clk);
    ca_trigger = 1'b1; dcyc = cyc;
    @(negedge clk);
    ca_trigger = 1'b0;
    checks++;
    if (ca_busy !== 1'b0) begin
      errors++; $display("FAIL basic_early_busy busy=%b required=0", ca_busy);
    end
    capture(word, nbits, blen, llen, dend, t0c, tmo);
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL basic_timeout got=%b required=0", tmo); end
    checks++;
    if (t0c !== dcyc + 2) begin errors++; $display("FAIL basic_latency t0=%0d required=%0d", t0c, dcyc + 2); end
    checks++;
    if (word !== 32'hF924B099 || nbits !== 32) begin
      errors++; $display("FAIL basic_bytes got=%h/%0d required=f924b099/32", word, nbits);
    end
    checks++;
    if (blen !== 130) begin errors++; $display("FAIL basic_busy_len got=%0d required=130", blen); end
    checks++;
    if (llen !== 2) begin errors++; $display("FAIL basic_load_len got=%0d required=2", llen); end
    checks++;
    if (dend !== 1'b1) begin errors++; $display("FAIL basic_done got=%b required=1", dend); end
    @(negedge clk);
    checks++;
    if (ca_done !== 1'b0 || ca_busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_width done=%b busy=%b required=0/0", ca_done, ca_busy);
    end
  endtask

  task automatic test_common_cathode();
    logic [31:0] word; int nbits, blen, llen, t0c; logic dend, tmo;
    sel = 1; cc_nums = 16'hA0F1; cc_dp = 4'b0000;
    @(negedge clk); cc_trigger = 1'b1;
    @(negedge clk); cc_trigger = 1'b0;
    capture(word, nbits, blen, llen, dend, t0c, tmo);
    checks++;
    if (tmo !== 1'b0 || word !== 32'h773F7106 || nbits !== 32) begin
      errors++; $display("FAIL cc_bytes got=%h/%0d tmo=%b required=773f7106/32", word, nbits, tmo);
    end
  endtask

  task automatic test_blanking();
    logic [31:0] word; int nbits, blen, llen, t0c; logic dend, tmo;
    sel = 2; bl_nums = 16'h0070; bl_dp = 4'b0000;
    @(negedge clk); bl_trigger = 1'b1;
    @(negedge clk); bl_trigger = 1'b0;
    capture(word, nbits, blen, llen, dend, t0c, tmo);
    checks++;
    if (tmo !== 1'b0 || word !== 32'hFFFFF8C0 || nbits !== 32) begin
      errors++; $display("FAIL blank_lead got=%h/%0d tmo=%b required=fffff8c0/32", word, nbits, tmo);
    end
    bl_dp = 4'b1000;
    repeat (3) @(negedge clk);
    bl_trigger = 1'b1;
    @(negedge clk); bl_trigger = 1'b0;
    capture(word, nbits, blen, llen, dend, t0c, tmo);
    checks++;
    if (tmo !== 1'b0 || word !== 32'h40C0F8C0 || nbits !== 32) begin
      errors++; $display("FAIL blank_dp_stop got=%h/%0d tmo=%b required=40c0f8c0/32", word, nbits, tmo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1, w2; int n1, n2, b1, b2, l1, l2, c1, c2, extra; logic d1, d2, x1, x2;
    sel = 0; ca_nums = 16'h1234; ca_dp = 4'b0000;
    repeat (3) @(negedge clk);
    ca_trigger = 1'b1;
    @(negedge clk); ca_trigger = 1'b0;
    fork
      capture(w1, n1, b1, l1, d1, c1, x1);
      begin
        for (int i = 0; i < 10 && !ca_busy; i++) @(negedge clk);
        repeat (29) @(negedge clk);
        ca_trigger = 1'b1;
        @(negedge clk); ca_trigger = 1'b0;
        repeat (9) @(negedge clk);
        ca_nums = 16'h5678;
        repeat (20) @(negedge clk);
        ca_trigger = 1'b1;
        @(negedge clk); ca_trigger = 1'b0;
      end
    join
    capture(w2, n2, b2, l2, d2, c2, x2);
    checks++;
    if (x1 !== 1'b0 || w1 !== 32'hF9A4B099) begin
      errors++; $display("FAIL queue_first got=%h tmo=%b required=f9a4b099", w1, x1);
    end
    checks++;
    if (x2 !== 1'b0 || w2 !== 32'h9282F880 || n2 !== 32) begin
      errors++; $display("FAIL queue_second got=%h/%0d tmo=%b required=9282f880/32", w2, n2, x2);
    end
    checks++;
    if (c2 !== c1 + 131) begin
      errors++; $display("FAIL queue_start got=%0d required=%0d", c2, c1 + 131);
    end
    extra = 0;
    repeat (300) begin
      @(negedge clk);
      if (ca_busy) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL queue_single_extra busy_cycles=%0d required=0", extra); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] word; int nbits, blen, llen, t0c, act; logic dend, tmo;
    sel = 0; ca_nums = 16'h1234; ca_dp = 4'b0000;
    @(negedge clk); ca_trigger = 1'b1;
    @(negedge clk); ca_trigger = 1'b0;
    for (int i = 0; i < 10 && !ca_busy; i++) @(negedge clk);
    repeat (49) @(negedge clk);
    checks++;
    if (ca_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy busy=%b required=1", ca_busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({ca_busy, ca_done, ca_sclk, ca_data, ca_load} !== 5'b0) begin
      errors++; $display("FAIL rst_async outputs=%b required=00000", {ca_busy, ca_done, ca_sclk, ca_data, ca_load});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    act = 0;
    repeat (40) begin
      @(negedge clk);
      if (ca_sclk || ca_busy || ca_load) act++;
    end
    checks++;
    if (act !== 0) begin errors++; $display("FAIL rst_no_resume active=%0d required=0", act); end
    ca_nums = 16'hBEEF; ca_dp = 4'b0001;
    ca_trigger = 1'b1;
    @(negedge clk); ca_trigger = 1'b0;
    capture(word, nbits, blen, llen, dend, t0c, tmo);
    checks++;
    if (tmo !== 1'b0 || word !== 32'h8386860E || nbits !== 32 || blen !== 130 || dend !== 1'b1) begin
      errors++; $display("FAIL rst_next_transfer got=%h/%0d/%0d done=%b required=8386860e/32/130/1",
                         word, nbits, blen, dend);
    end
  endtask

  task automatic test_refresh();
    logic [31:0] wa, wb, wc; int n, b, l, ta, tb, tc; logic d, xa, xb, xc;
    sel = 3;
    @(negedge clk); rf_trigger = 1'b1;
    @(negedge clk); rf_trigger = 1'b0;
    for (int i = 0; i < 400 && !rf_busy; i++) @(negedge clk);
    for (int i = 0; i < 400 && rf_busy; i++) @(negedge clk);
    rf_nums = 16'h89AB;
    capture(wa, n, b, l, d, ta, xa);
    rf_nums = 16'hCDEF;
    capture(wb, n, b, l, d, tb, xb);
    capture(wc, n, b, l, d, tc, xc);
    checks++;
    if (xa !== 1'b0 || wa !== 32'h80908883) begin
      errors++; $display("FAIL refresh_a got=%h tmo=%b required=80908883", wa, xa);
    end
    checks++;
    if (xb !== 1'b0 || wb !== 32'hC6A1868E) begin
      errors++; $display("FAIL refresh_recapture got=%h tmo=%b required=c6a1868e", wb, xb);
    end
    checks++;
    if (tb - ta !== 150) begin errors++; $display("FAIL refresh_period_ab got=%0d required=150", tb - ta); end
    checks++;
    if (xc !== 1'b0 || wc !== 32'hC6A1868E || tc - tb !== 150) begin
      errors++; $display("FAIL refresh_period_bc got=%h/%0d required=c6a1868e/150", wc, tc - tb);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_common_cathode();
    test_blanking();
    test_back_to_back();
    test_reset_mid();
    test_refresh();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
